// File: rtl/counter_ctrl_if.sv
// Command channel between software-visible command logic and counter_ctrl.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The master holds cmd_op/cmd_arg stable while
// cmd_valid is high and not yet accepted. cmd_ready may be low for many cycles
// (the controller is busy). Offering a command while cmd_ready is low has no
// effect. cmd_ready does not depend on cmd_valid.
interface counter_ctrl_if #(
    parameter int N = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/counter_ctrl.sv
// Command sequencer for a mod-M up/down counter. It takes one command at a time
// (CLEAR, LOAD, UP K, DOWN K) and drives the counter controls one action per
// cycle. It forces a true modulo-M wrap, because the counter itself only wraps
// at 2^N. Completion is signalled with a one-cycle done pulse.
module counter_ctrl #(
    parameter int N = 8,
    parameter int M = 163
) (
    input  logic         clk,
    input  logic         reset,
    counter_ctrl_if.slave cmd,
    input  logic [N-1:0] cnt_q_i,
    input  logic         cnt_max_tick_i,
    input  logic         cnt_min_tick_i,
    output logic         cnt_clr_o,
    output logic         cnt_load_o,
    output logic         cnt_en_o,
    output logic         cnt_up_o,
    output logic [N-1:0] cnt_d_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic         wrap_o,
    output logic [1:0]   state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    // The LOAD range check compares against M with one extra bit, so that
    // M == 2^N (every N-bit value legal) still works.
    localparam logic [N:0]   M_EXT = (N+1)'(M);
    localparam logic [N-1:0] M_TOP = N'(M - 1);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [N-1:0] arg_q, arg_d;
    logic [N-1:0] rem_q, rem_d;
    logic         err_q, err_d;

    // The wrap decisions use only the counter's tick flags. The counter value
    // is on the port so the pin list matches the counter, but nothing here needs it.
    logic unused_cnt_q;
    assign unused_cnt_q = ^cnt_q_i;

    // Control state register. Reset abandons any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_CLEAR;
            arg_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode. The counter controls come from registered
    // state plus the live tick flags, so a wrap is issued in the same cycle
    // that the counter reports the boundary.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        rem_d   = rem_q;
        err_d   = err_q;

        cmd.cmd_ready = 1'b0;
        cnt_clr_o     = 1'b0;
        cnt_load_o    = 1'b0;
        cnt_en_o      = 1'b0;
        cnt_up_o      = 1'b0;
        cnt_d_o       = '0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        err_o         = 1'b0;
        wrap_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    op_d  = op_e'(cmd.cmd_op);
                    arg_d = cmd.cmd_arg;
                    case (op_e'(cmd.cmd_op))
                        OP_CLEAR: begin
                            state_d = ST_RUN;
                        end
                        OP_LOAD: begin
                            if ({1'b0, cmd.cmd_arg} < M_EXT) begin
                                state_d = ST_RUN;
                            end else begin
                                // Out-of-range value: report it and do not touch the counter.
                                state_d = ST_DONE;
                                err_d   = 1'b1;
                            end
                        end
                        default: begin
                            // UP / DOWN: K steps, a zero count finishes at once.
                            rem_d   = cmd.cmd_arg;
                            state_d = (cmd.cmd_arg == '0) ? ST_DONE : ST_RUN;
                        end
                    endcase
                end
            end

            ST_RUN: begin
                busy_o = 1'b1;
                case (op_q)
                    OP_CLEAR: begin
                        cnt_clr_o = 1'b1;
                        state_d   = ST_DONE;
                    end
                    OP_LOAD: begin
                        cnt_load_o = 1'b1;
                        cnt_d_o    = arg_q;
                        state_d    = ST_DONE;
                    end
                    OP_UP: begin
                        if (cnt_max_tick_i) begin
                            // At M-1: the next value is 0. Clear, do not increment.
                            cnt_clr_o = 1'b1;
                            wrap_o    = 1'b1;
                        end else begin
                            cnt_en_o = 1'b1;
                            cnt_up_o = 1'b1;
                        end
                        rem_d = rem_q - 1'b1;
                        if (rem_q <= N'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                    default: begin
                        if (cnt_min_tick_i) begin
                            // At 0: the next value is M-1, not 2^N-1.
                            cnt_load_o = 1'b1;
                            cnt_d_o    = M_TOP;
                            wrap_o     = 1'b1;
                        end else begin
                            cnt_en_o = 1'b1;
                        end
                        rem_d = rem_q - 1'b1;
                        if (rem_q <= N'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                endcase
            end

            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                err_o   = err_q;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl. It connects the controller to a small
// behavioural model of the mod-M counter. The model wraps only at 2^N, so any
// modulo-M behaviour seen here comes from the controller.
module tb_counter_ctrl;

    localparam int N = 8;
    localparam int M = 163;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;
    localparam logic [1:0] OP_DOWN  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    counter_ctrl_if #(.N(N)) cmd_bus ();

    logic [N-1:0] cnt_q = '0;
    logic         cnt_max_tick, cnt_min_tick;
    logic         cnt_clr, cnt_load, cnt_en, cnt_up;
    logic [N-1:0] cnt_d;
    logic         busy, done, err, wrap;
    logic [1:0]   state;
    logic [4:0]   ctl;

    int n_cmp  = 0;
    int n_fail = 0;

    counter_ctrl #(.N(N), .M(M)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (cmd_bus.slave),
        .cnt_q_i        (cnt_q),
        .cnt_max_tick_i (cnt_max_tick),
        .cnt_min_tick_i (cnt_min_tick),
        .cnt_clr_o      (cnt_clr),
        .cnt_load_o     (cnt_load),
        .cnt_en_o       (cnt_en),
        .cnt_up_o       (cnt_up),
        .cnt_d_o        (cnt_d),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .wrap_o         (wrap),
        .state_o        (state)
    );

    // Counter model: the priority is clr, then load, then en. It wraps at 2^N only.
    always @(posedge clk) begin
        if (cnt_clr)       cnt_q <= '0;
        else if (cnt_load) cnt_q <= cnt_d;
        else if (cnt_en)   cnt_q <= cnt_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
    assign cnt_max_tick = (cnt_q == N'(M - 1));
    assign cnt_min_tick = (cnt_q == '0);

    // {clr, load, en, up, wrap}
    assign ctl = {cnt_clr, cnt_load, cnt_en, cnt_up, wrap};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // Offers one command for a single cycle. The call returns just after the
    // accepting edge, so the next negedge is the first cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [N-1:0] arg);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b0;
    endtask

    // Puts the counter at v through a valid LOAD and waits until the controller is back in IDLE.
    task automatic preload(input logic [N-1:0] v);
        send(OP_LOAD, v);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cmd_bus.cmd_ready, busy, done, err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_status: got rdy/busy/done/err=%b want 1000",
                     {cmd_bus.cmd_ready, busy, done, err});
        end
        n_cmp++;
        if ({ctl, cnt_d} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_cnt_ctrl: got ctl=%b d=%0d want 0/0", ctl, cnt_d);
        end
        n_cmp++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cmd_bus.cmd_ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy/busy/done=%b want 100",
                     {cmd_bus.cmd_ready, busy, done});
        end
    endtask

    task automatic test_load();
        send(OP_LOAD, 8'd100);
        @(negedge clk);
        n_cmp++;
        if ({ctl, cnt_d, busy, done} !== {5'b01000, 8'd100, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL load_run: got ctl=%b d=%0d busy=%b done=%b want 01000/100/1/0",
                     ctl, cnt_d, busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err, ctl} !== {2'b10, 5'b00000}) begin
            n_fail++;
            $display("FAIL load_done: got done/err=%b ctl=%b want 10/00000", {done, err}, ctl);
        end
        n_cmp++;
        if (cnt_q !== 8'd100) begin
            n_fail++;
            $display("FAIL load_value: got %0d want 100", cnt_q);
        end
        @(negedge clk);
        // The out-of-range LOAD reports err in the next cycle and leaves the counter alone.
        send(OP_LOAD, 8'd200);
        @(negedge clk);
        n_cmp++;
        if ({done, err, ctl} !== {2'b11, 5'b00000}) begin
            n_fail++;
            $display("FAIL load_bad_done: got done/err=%b ctl=%b want 11/00000", {done, err}, ctl);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err, cmd_bus.cmd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL load_bad_after: got done/err/rdy=%b want 001",
                     {done, err, cmd_bus.cmd_ready});
        end
        n_cmp++;
        if (cnt_q !== 8'd100) begin
            n_fail++;
            $display("FAIL load_bad_value: got %0d want 100", cnt_q);
        end
        // M-1 is the largest legal LOAD value.
        preload(8'd162);
        n_cmp++;
        if (cnt_q !== 8'd162) begin
            n_fail++;
            $display("FAIL load_top: got %0d want 162", cnt_q);
        end
    endtask

    task automatic test_plain_up();
        preload(8'd5);
        send(OP_UP, 8'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ctl, done} !== {5'b00110, 1'b0}) begin
                n_fail++;
                $display("FAIL plain_up_ctl[%0d]: got ctl=%b done=%b want 00110/0", i, ctl, done);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err, ctl} !== {2'b10, 5'b00000}) begin
            n_fail++;
            $display("FAIL plain_up_done: got done/err=%b ctl=%b want 10/00000", {done, err}, ctl);
        end
        n_cmp++;
        if (cnt_q !== 8'd8) begin
            n_fail++;
            $display("FAIL plain_up_value: got %0d want 8", cnt_q);
        end
    endtask

    task automatic test_up_wrap();
        logic [4:0] exp_ctl [5];
        int wraps;
        exp_ctl[0] = 5'b00110;
        exp_ctl[1] = 5'b00110;
        exp_ctl[2] = 5'b10001;
        exp_ctl[3] = 5'b00110;
        exp_ctl[4] = 5'b00110;
        wraps = 0;
        preload(8'd160);
        send(OP_UP, 8'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wrap) wraps++;
            n_cmp++;
            if (ctl !== exp_ctl[i]) begin
                n_fail++;
                $display("FAIL up_wrap_ctl[%0d]: got %b want %b", i, ctl, exp_ctl[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL up_wrap_done: got done/err=%b want 10", {done, err});
        end
        n_cmp++;
        if (cnt_q !== 8'd2) begin
            n_fail++;
            $display("FAIL up_wrap_value: got %0d want 2", cnt_q);
        end
        n_cmp++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL up_wrap_count: got %0d want 1", wraps);
        end
    endtask

    task automatic test_down_wrap();
        logic [4:0]   exp_ctl [3];
        logic [N-1:0] exp_d   [3];
        exp_ctl[0] = 5'b00100; exp_d[0] = 8'd0;
        exp_ctl[1] = 5'b01001; exp_d[1] = 8'd162;
        exp_ctl[2] = 5'b00100; exp_d[2] = 8'd0;
        preload(8'd1);
        send(OP_DOWN, 8'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ctl, cnt_d} !== {exp_ctl[i], exp_d[i]}) begin
                n_fail++;
                $display("FAIL down_wrap_ctl[%0d]: got ctl=%b d=%0d want %b/%0d",
                         i, ctl, cnt_d, exp_ctl[i], exp_d[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL down_wrap_done: got done/err=%b want 10", {done, err});
        end
        n_cmp++;
        if (cnt_q !== 8'd161) begin
            n_fail++;
            $display("FAIL down_wrap_value: got %0d want 161", cnt_q);
        end
    endtask

    task automatic test_clear();
        preload(8'd77);
        send(OP_CLEAR, 8'd55);
        @(negedge clk);
        n_cmp++;
        if ({ctl, done} !== {5'b10000, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_run: got ctl=%b done=%b want 10000/0", ctl, done);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err, cnt_q} !== {2'b10, 8'd0}) begin
            n_fail++;
            $display("FAIL clear_done: got done/err=%b q=%0d want 10/0", {done, err}, cnt_q);
        end
    endtask

    task automatic test_k_zero();
        preload(8'd42);
        send(OP_UP, 8'd0);
        @(negedge clk);
        n_cmp++;
        if ({done, err, ctl, cmd_bus.cmd_ready} !== {2'b10, 5'b00000, 1'b0}) begin
            n_fail++;
            $display("FAIL k_zero_done: got done/err=%b ctl=%b rdy=%b want 10/00000/0",
                     {done, err}, ctl, cmd_bus.cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, cmd_bus.cmd_ready, cnt_q} !== {2'b01, 8'd42}) begin
            n_fail++;
            $display("FAIL k_zero_after: got done/rdy=%b q=%0d want 01/42",
                     {done, cmd_bus.cmd_ready}, cnt_q);
        end
    endtask

    task automatic test_back_to_back();
        preload(8'd10);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_UP;
        cmd_bus.cmd_arg   = 8'd2;
        @(posedge clk);
        #1;
        // The next command is already on the bus while the first one is still running.
        cmd_bus.cmd_op  = OP_DOWN;
        cmd_bus.cmd_arg = 8'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ctl, cmd_bus.cmd_ready, state} !== {5'b00110, 1'b0, 2'd1}) begin
                n_fail++;
                $display("FAIL b2b_first[%0d]: got ctl=%b rdy=%b st=%0d want 00110/0/1",
                         i, ctl, cmd_bus.cmd_ready, state);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, cmd_bus.cmd_ready, ctl} !== {2'b10, 5'b00000}) begin
            n_fail++;
            $display("FAIL b2b_done_cycle: got done/rdy=%b ctl=%b want 10/00000",
                     {done, cmd_bus.cmd_ready}, ctl);
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_bus.cmd_ready, busy, state} !== {2'b10, 2'd0}) begin
            n_fail++;
            $display("FAIL b2b_idle: got rdy/busy=%b st=%0d want 10/0",
                     {cmd_bus.cmd_ready, busy}, state);
        end
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ctl, busy} !== {5'b00100, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second: got ctl=%b busy=%b want 00100/1", ctl, busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, cnt_q} !== {1'b1, 8'd11}) begin
            n_fail++;
            $display("FAIL b2b_second_done: got done=%b q=%0d want 1/11", done, cnt_q);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        preload(8'd0);
        send(OP_UP, 8'd10);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ctl, cnt_d, busy, done, err} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got ctl=%b d=%0d busy/done/err=%b want all 0",
                     ctl, cnt_d, {busy, done, err});
        end
        n_cmp++;
        if ({cmd_bus.cmd_ready, state} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got rdy=%b st=%0d want 1/0", cmd_bus.cmd_ready, state);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d done pulses want 0", dones);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'b00;
        cmd_bus.cmd_arg   = '0;
        test_reset();
        test_load();
        test_plain_up();
        test_up_wrap();
        test_down_wrap();
        test_clear();
        test_k_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
